// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
// card_pkg
// Shared card-state encodings, write-entry layout and arbiter state type.
// Revision: 1.0
// ============================================================================
package card_pkg;

  localparam int CARD_ADDR_W  = 4;
  localparam int CARD_STATE_W = 2;

  localparam logic [CARD_STATE_W-1:0] COVERED     = 2'b01;
  localparam logic [CARD_STATE_W-1:0] DEACTIVATED = 2'b10;
  localparam logic [CARD_STATE_W-1:0] DISCOVERED  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2
  } arb_state_e;

  // One buffered game write: {state, addr}, 6 bits for the default build.
  typedef struct packed {
    logic [CARD_STATE_W-1:0] state;
    logic [CARD_ADDR_W-1:0]  addr;
  } card_wr_t;

endpackage
`default_nettype wire

// File: rtl/card_wr_fifo.sv
`default_nettype none
// ============================================================================
// card_wr_fifo
// Synchronous game-write buffer with full/empty flags, occupancy count and a
// push-to-head bypass so a write into an empty buffer can issue the same cycle.
// Revision: 1.0
// ============================================================================
module card_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     head_valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;
  logic             do_push;
  logic             bypass;
  logic             wr_mem;
  logic             rd_adv;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign head_valid_o = !empty_o || push_i;
  assign head_o       = empty_o ? push_data_i : mem_q[rptr_q];
  assign count_o      = count_q;

  // A pop frees a slot, so a push while full is still accepted in that cycle.
  always_comb begin
    do_pop  = pop_i && head_valid_o;
    do_push = push_i && (!full_o || do_pop);
    bypass  = empty_o && do_push && do_pop;
    wr_mem  = do_push && !bypass;
    rd_adv  = do_pop && !bypass;
    wptr_d  = wr_mem ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = rd_adv ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q + CNT_W'(wr_mem) - CNT_W'(rd_adv);
  end

  always_ff @(posedge clk) begin
    if (wr_mem) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/card_write_arbiter.sv
`default_nettype none
// ============================================================================
// card_write_arbiter
// Shares the card-state RAM write port between buffered game writes and a
// full clear sweep, keeping program order around each clear.
// Optional feature macro: CARD_WR_STATS_EN (deactivate-write counter).
// Revision: 1.0
// ============================================================================
module card_write_arbiter
  import card_pkg::*;
#(
  parameter int                      NUM_CARDS   = 16,
  parameter int                      FIFO_DEPTH  = 4,
  parameter logic [CARD_STATE_W-1:0] CLEAR_STATE = COVERED
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fsm_wr_en,
  input  logic [CARD_STATE_W-1:0] fsm_wr_state,
  input  logic [CARD_ADDR_W-1:0]  fsm_wr_addr,
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic                    ram_we,
  output logic [CARD_ADDR_W-1:0]  ram_addr,
  output logic [CARD_STATE_W-1:0] ram_wdata,
  output logic                    fifo_full,
  output logic                    overflow,
  output logic [3:0]              cards_done
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int SWEEP_W = CARD_ADDR_W + 1;

  arb_state_e              state_q, state_d;
  logic [CNT_W-1:0]        drain_q, drain_d;
  logic [SWEEP_W-1:0]      sweep_q, sweep_d;
  logic                    overflow_q, overflow_d;
  logic                    ram_we_q;
  logic [CARD_ADDR_W-1:0]  ram_addr_q;
  logic [CARD_STATE_W-1:0] ram_wdata_q;

  card_wr_t                push_ent;
  card_wr_t                head_ent;
  logic                    head_valid;
  logic                    fifo_pop;
  logic                    fifo_full_w;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;

  logic                    issue_we;
  logic [CARD_ADDR_W-1:0]  issue_addr;
  logic [CARD_STATE_W-1:0] issue_data;
  logic                    sweep_first;

  assign push_ent.state = fsm_wr_state;
  assign push_ent.addr  = fsm_wr_addr;

  card_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(card_wr_t))
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (fsm_wr_en),
    .push_data_i  (push_ent),
    .pop_i        (fifo_pop),
    .head_o       (head_ent),
    .head_valid_o (head_valid),
    .full_o       (fifo_full_w),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  // Outputs are registered, so each branch decides what the RAM sees next
  // cycle. The sweep starts issuing in the clear cycle only when nothing is
  // popped then; sweep_q == NUM_CARDS is the tail cycle showing the last address.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    sweep_d     = sweep_q;
    fifo_pop    = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_data  = '0;
    sweep_first = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            issue_we   = 1'b1;
            issue_addr = head_ent.addr;
            issue_data = head_ent.state;
            drain_d    = fifo_count - CNT_W'(1);
            sweep_d    = '0;
            state_d    = (fifo_count > CNT_W'(1)) ? DRAIN : SWEEP;
          end else begin
            issue_we    = 1'b1;
            issue_addr  = '0;
            issue_data  = CLEAR_STATE;
            sweep_first = 1'b1;
            sweep_d     = SWEEP_W'(1);
            state_d     = SWEEP;
          end
        end else if (head_valid) begin
          fifo_pop   = 1'b1;
          issue_we   = 1'b1;
          issue_addr = head_ent.addr;
          issue_data = head_ent.state;
        end
      end
      DRAIN: begin
        fifo_pop   = 1'b1;
        issue_we   = 1'b1;
        issue_addr = head_ent.addr;
        issue_data = head_ent.state;
        drain_d    = drain_q - CNT_W'(1);
        if (drain_q == CNT_W'(1)) begin
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (sweep_q == SWEEP_W'(NUM_CARDS)) begin
          sweep_d = '0;
          state_d = IDLE;
        end else begin
          issue_we    = 1'b1;
          issue_addr  = sweep_q[CARD_ADDR_W-1:0];
          issue_data  = CLEAR_STATE;
          sweep_first = (sweep_q == '0);
          sweep_d     = sweep_q + SWEEP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign overflow_d = overflow_q | (fsm_wr_en && fifo_full_w && !fifo_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      sweep_q     <= '0;
      overflow_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      sweep_q     <= sweep_d;
      overflow_q  <= overflow_d;
      ram_we_q    <= issue_we;
      ram_addr_q  <= issue_addr;
      ram_wdata_q <= issue_data;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign clear_busy = (state_q != IDLE);
  assign fifo_full  = fifo_full_w;
  assign overflow   = overflow_q;

`ifdef CARD_WR_STATS_EN
  logic [3:0] cards_done_q, cards_done_d;

  // Counts deactivate writes as they are issued; the sweep's first write zeroes it.
  always_comb begin
    cards_done_d = cards_done_q;
    if (sweep_first) begin
      cards_done_d = '0;
    end else if (fifo_pop && (head_ent.state == DEACTIVATED) && (cards_done_q != 4'hF)) begin
      cards_done_d = cards_done_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cards_done_q <= '0;
    end else begin
      cards_done_q <= cards_done_d;
    end
  end

  assign cards_done = cards_done_q;
`else
  assign cards_done = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_card_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_card_write_arbiter
// Randomized and directed stimulus against a queue-based reference model;
// a negedge monitor pops cycle-tagged expectations and compares.
// Revision: 1.0
// ============================================================================
module tb_card_write_arbiter;

  localparam int DEPTH  = 4;
  localparam int NCARDS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fsm_wr_en = 1'b0;
  logic [1:0] fsm_wr_state = 2'b00;
  logic [3:0] fsm_wr_addr = 4'd0;
  logic       clear_req = 1'b0;
  logic       clear_busy;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [1:0] ram_wdata;
  logic       fifo_full;
  logic       overflow;
  logic [3:0] cards_done;

  card_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .fsm_wr_en    (fsm_wr_en),
    .fsm_wr_state (fsm_wr_state),
    .fsm_wr_addr  (fsm_wr_addr),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .cards_done   (cards_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [3:0] addr; logic [1:0] data; } wr_t;
  typedef struct { int cyc; bit busy; bit full; bit ovf; int cd; } st_t;
  typedef struct { logic [1:0] st; logic [3:0] ad; } ent_t;

  wr_t  exp_q[$];
  st_t  st_q[$];
  ent_t pend[$];

  int m_nopop;
  int m_drain;
  int m_cd;
  int m_cd_zero;
  bit m_ovf;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  wr_t mon_e;
  st_t mon_s;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    st_q.delete();
    m_nopop   = 0;
    m_drain   = 0;
    m_cd      = 0;
    m_cd_zero = -1;
    m_ovf     = 0;
  endtask

  // A write decided this cycle is visible on the RAM port next cycle.
  task automatic model_issue(input ent_t e);
    exp_q.push_back('{cyc + 1, e.ad, e.st});
`ifdef CARD_WR_STATS_EN
    if (e.st == 2'b10 && m_cd < 15) m_cd++;
`endif
  endtask

  task automatic model_sweep(input int t0);
    for (int i = 0; i < NCARDS; i++) exp_q.push_back('{t0 + i, 4'(i), 2'b01});
    m_cd_zero = t0;
  endtask

  // Spec rules: old entries drain first, then 16 no-pop sweep writes; new
  // writes wait in the queue, and a write to a full queue with no pop is lost.
  task automatic model_step(input bit wr, input ent_t e, input bit clr);
    bit   popped;
    bit   consumed;
    int   sz;
    ent_t hd;
    popped   = 0;
    consumed = 0;
    sz       = pend.size();
    if (m_nopop > 0) begin
      m_nopop--;
    end else if (m_drain > 0) begin
      hd = pend.pop_front(); popped = 1; model_issue(hd);
      m_drain--;
      if (m_drain == 0) begin model_sweep(cyc + 2); m_nopop = NCARDS + 1; end
    end else if (clr) begin
      if (sz > 0) begin
        hd = pend.pop_front(); popped = 1; model_issue(hd);
        m_drain = sz - 1;
        if (m_drain == 0) begin model_sweep(cyc + 2); m_nopop = NCARDS + 1; end
      end else begin
        model_sweep(cyc + 1);
        m_nopop = NCARDS;
      end
    end else if (sz > 0) begin
      hd = pend.pop_front(); popped = 1; model_issue(hd);
    end else if (wr) begin
      popped = 1; consumed = 1; model_issue(e);
    end
    if (wr && !consumed) begin
      if (sz < DEPTH || popped) pend.push_back(e);
      else m_ovf = 1;
    end
    if (m_cd_zero == cyc + 1) m_cd = 0;
    st_q.push_back('{cyc + 1, (m_nopop > 0 || m_drain > 0), (pend.size() == DEPTH), m_ovf, m_cd});
  endtask

  task automatic step(input bit wr, input logic [1:0] st, input logic [3:0] ad, input bit clr);
    ent_t e;
    e.st = st;
    e.ad = ad;
    fsm_wr_en    = wr;
    fsm_wr_state = st;
    fsm_wr_addr  = ad;
    clear_req    = clr;
    model_step(wr, e, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 4'd0, 0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((m_nopop > 0 || m_drain > 0) && guard < 100) begin
      step(0, 2'b00, 4'd0, 0);
      guard++;
    end
    check("wait_idle_budget", guard < 100 ? 1 : 0, 1);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        check("ram_write_missed_cycle", cyc, mon_e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        check("ram_we", int'(ram_we), 1);
        check("ram_addr", int'(ram_addr), int'(mon_e.addr));
        check("ram_wdata", int'(ram_wdata), int'(mon_e.data));
      end else begin
        check("ram_idle_outputs", int'({ram_we, ram_addr, ram_wdata}), 0);
      end
      while (st_q.size() > 0 && st_q[0].cyc < cyc) void'(st_q.pop_front());
      if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
        mon_s = st_q.pop_front();
        check("clear_busy", int'(clear_busy), int'(mon_s.busy));
        check("fifo_full", int'(fifo_full), int'(mon_s.full));
        check("overflow", int'(overflow), int'(mon_s.ovf));
        check("cards_done", int'(cards_done), mon_s.cd);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_we"}, int'(ram_we), 0);
    check({tag, "_ram_addr"}, int'(ram_addr), 0);
    check({tag, "_ram_wdata"}, int'(ram_wdata), 0);
    check({tag, "_clear_busy"}, int'(clear_busy), 0);
    check({tag, "_fifo_full"}, int'(fifo_full), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_cards_done"}, int'(cards_done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst    = 1'b1;
    mon_en = 1;

    idle(5);
    step(1, 2'b11, 4'd5, 0);
    idle(8);

    step(0, 2'b00, 4'd0, 1);
    idle(20);

    step(0, 2'b00, 4'd0, 1);
    idle(2);
    step(1, 2'b11, 4'd1, 0);
    step(1, 2'b01, 4'd2, 0);
    step(1, 2'b11, 4'd3, 0);
    wait_idle();
    step(1, 2'b11, 4'd9, 1);
    idle(25);

    step(0, 2'b00, 4'd0, 1);
    step(1, 2'b11, 4'd4, 0);
    step(1, 2'b01, 4'd5, 0);
    step(1, 2'b10, 4'd6, 0);
    step(1, 2'b11, 4'd10, 0);
    step(1, 2'b11, 4'd7, 0);
    wait_idle();
    idle(10);

    for (int i = 0; i < 4; i++) begin
      step(1, 2'b10, 4'(i + 11), 0);
      idle(1);
    end
    idle(3);
    step(0, 2'b00, 4'd0, 1);
    wait_idle();
    idle(3);

    step(0, 2'b00, 4'd0, 1);
    idle(8);
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_sweep");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 2'b11, 4'd3, 0);
    idle(5);

    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0));
    end
    wait_idle();
    idle(30);
    check("expected_writes_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
